// File: rtl/pc_flow_ctrl_pkg.sv
// Shared definitions for the pc_flow_ctrl stage: return-stack operation codes
// and the constant clog2 helper used to size pointers and counters.
package pc_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    // Ceiling log2; clog2(1) is 0, so callers size for at least one bit where needed.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack: DEPTH x NBITS register file, a modulo-DEPTH
// stack pointer and a saturating depth counter with sticky overflow/underflow.
module pc_ret_stack
    import pc_flow_ctrl_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int DEPTH = 8,
    localparam int SPW  = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] top,
    output logic [SPW-1:0]   depth,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = clog2(DEPTH);
    localparam logic [SPW-1:0] FULL = SPW'(DEPTH);
    localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

    logic [NBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    sp;
    logic [AW-1:0]    sp_inc;
    logic [AW-1:0]    sp_dec;
    logic [AW-1:0]    waddr;
    logic             wen;
    logic             empty;
    logic             full;
    stack_op_e        op;

    // Pointer wraps explicitly so non-power-of-two depths behave as a true modulo counter.
    always_comb begin
        op = OP_NONE;
        case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        empty  = (depth == '0);
        full   = (depth == FULL);
        sp_inc = (sp == LAST) ? '0 : sp + AW'(1);
        sp_dec = (sp == '0) ? LAST : sp - AW'(1);
        wen    = rst && (op == OP_PUSH || op == OP_REPLACE);
        waddr  = (op == OP_REPLACE && !empty) ? sp_dec : sp;
        top    = empty ? '0 : mem[sp_dec];
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // A replace on an empty stack degenerates to a push, but still flags the missing pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp    <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    sp <= sp_inc;
                    if (full) begin
                        ovf <= 1'b1;
                    end else begin
                        depth <= depth + SPW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf <= 1'b1;
                    end else begin
                        sp    <= sp_dec;
                        depth <= depth - SPW'(1);
                    end
                end
                OP_REPLACE: begin
                    if (empty) begin
                        sp    <= sp_inc;
                        depth <= depth + SPW'(1);
                        unf   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Flow-control stage ahead of the PC: decodes jump/call/return strobes into the
// PC load/data inputs and manages the return-address stack.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int DEPTH = 8,
    localparam int SPW  = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [NBITS-1:0] tgt,
    input  logic [NBITS-1:0] addr,
    output logic             load,
    output logic [NBITS-1:0] data,
    output logic [SPW-1:0]   depth,
    output logic             ovf,
    output logic             unf
);

    logic [NBITS-1:0] top;

    pc_ret_stack #(
        .NBITS(NBITS),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (call),
        .pop  (ret),
        .wdata(addr),
        .top  (top),
        .depth(depth),
        .ovf  (ovf),
        .unf  (unf)
    );

    // Combinational so the PC can mux the redirect into its register this cycle.
    always_comb begin
        load = 1'b0;
        data = '0;
        if (rst) begin
            load = jmp | call | ret;
            if (call) begin
                data = tgt;
            end else if (ret) begin
                data = top;
            end else if (jmp) begin
                data = tgt;
            end
        end
    end

endmodule
